// File: rtl/packet_xor_scheduler_if.sv
// Scheduler-side bus: mask RAM read port, packet-XOR datapath gating/result, and result stream.
// The master side is the scheduler; the slave side is RAM + datapath + downstream consumer.
interface packet_xor_scheduler_if #(
  parameter int K_MAX         = 128,
  parameter int M_MAX         = 128,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2
);
  localparam int ROW_W = $clog2(M_MAX*W);

  logic                     mask_rd_en_o;
  logic [ROW_W-1:0]         mask_rd_addr_o;
  logic [K_MAX*W-1:0]       mask_rd_data_i;
  logic [K_MAX*W-1:0]       xor_mask_o;
  logic [PACKET_LENGTH-1:0] xor_result_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [PACKET_LENGTH-1:0] out_data_o;
  logic [ROW_W-1:0]         out_row_o;

  modport master (
    output mask_rd_en_o, mask_rd_addr_o, xor_mask_o, out_valid_o, out_data_o, out_row_o,
    input  mask_rd_data_i, xor_result_i, out_ready_i
  );

  modport slave (
    input  mask_rd_en_o, mask_rd_addr_o, xor_mask_o, out_valid_o, out_data_o, out_row_o,
    output mask_rd_data_i, xor_result_i, out_ready_i
  );
endinterface

// File: rtl/packet_xor_scheduler.sv
// Walks all m*W parity rows of one encode job: fetch mask, trim to k, gate datapath, stream result.
// Optional backpressure counter on stall_cnt_o enabled by PACKET_XOR_SCHED_STALL_CNT_EN.
module packet_xor_scheduler #(
  parameter int K_MAX         = 128,
  parameter int K_MIN         = 2,
  parameter int M_MAX         = 128,
  parameter int M_MIN         = 2,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [$clog2(K_MAX+1)-1:0]   k_cfg_i,
  input  logic [$clog2(M_MAX+1)-1:0]   m_cfg_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         cfg_err_o,
  output logic [15:0]                  stall_cnt_o,
  packet_xor_scheduler_if.master       bus
);
  localparam int KW     = $clog2(K_MAX+1);
  localparam int MW     = $clog2(M_MAX+1);
  localparam int ROW_W  = $clog2(M_MAX*W);
  localparam int RCW    = $clog2(M_MAX*W+1);
  localparam int MASK_W = K_MAX*W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_APPLY, S_CAPTURE, S_OUT, S_DONE
  } state_t;

  state_t                   r_state, w_state_next;
  logic [KW-1:0]            r_k;
  logic [MW-1:0]            r_m;
  logic [ROW_W-1:0]         r_row;
  logic [MASK_W-1:0]        r_xor_mask;
  logic [MASK_W-1:0]        w_mask_trim;
  logic [K_MAX-1:0]         w_pkt_en;
  logic                     r_out_valid;
  logic [PACKET_LENGTH-1:0] r_out_data;
  logic [ROW_W-1:0]         r_out_row;
  logic                     r_cfg_err;
  logic                     w_cfg_ok, w_start_acc, w_accept, w_last;
  logic [RCW-1:0]           w_row_last;

  assign w_cfg_ok    = (k_cfg_i >= KW'(K_MIN)) && (k_cfg_i <= KW'(K_MAX)) &&
                       (m_cfg_i >= MW'(M_MIN)) && (m_cfg_i <= MW'(M_MAX));
  assign w_start_acc = (r_state == S_IDLE) && start_i && w_cfg_ok;
  assign w_accept    = r_out_valid && bus.out_ready_i;
  assign w_row_last  = RCW'(r_m) * RCW'(W) - RCW'(1);
  assign w_last      = (RCW'(r_row) == w_row_last);

  // Packets at index >= k do not take part in this job, so their words are gated off.
  for (genvar gi = 0; gi < K_MAX; gi++) begin : g_trim
    assign w_pkt_en[gi]             = (KW'(gi) < r_k);
    assign w_mask_trim[gi*W +: W]   = bus.mask_rd_data_i[gi*W +: W] & {W{w_pkt_en[gi]}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    busy_o           = 1'b1;
    done_o           = 1'b0;
    bus.mask_rd_en_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_start_acc) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        bus.mask_rd_en_o = 1'b1;
        w_state_next     = S_APPLY;
      end
      S_APPLY:   w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_OUT;
      S_OUT: begin
        if (w_accept) w_state_next = w_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k         <= '0;
      r_m         <= '0;
      r_row       <= '0;
      r_xor_mask  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == S_IDLE) && start_i && !w_cfg_ok;
      if (w_start_acc) begin
        r_k   <= k_cfg_i;
        r_m   <= m_cfg_i;
        r_row <= '0;
      end
      // RAM data arrives during APPLY; the mask then holds until the next row or job end.
      if (r_state == S_APPLY) r_xor_mask <= w_mask_trim;
      if (r_state == S_DONE)  r_xor_mask <= '0;
      if (r_state == S_CAPTURE) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.xor_result_i;
        r_out_row   <= r_row;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
        if (!w_last) r_row <= r_row + ROW_W'(1);
      end
    end
  end

  assign cfg_err_o          = r_cfg_err;
  assign bus.mask_rd_addr_o = r_row;
  assign bus.xor_mask_o     = r_xor_mask;
  assign bus.out_valid_o    = r_out_valid;
  assign bus.out_data_o     = r_out_data;
  assign bus.out_row_o      = r_out_row;

`ifdef PACKET_XOR_SCHED_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                    r_stall_cnt <= '0;
    else if (w_start_acc)                                       r_stall_cnt <= '0;
    else if (r_out_valid && !bus.out_ready_i && r_stall_cnt != 16'hFFFF)
                                                                r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_packet_xor_scheduler.sv
// Directed bench for packet_xor_scheduler: one-hot and all-ones mask rows, illegal configs,
// backpressure, start while busy, and asynchronous reset in the middle of a job.
module tb_packet_xor_scheduler;
  localparam int MASK_W = 512;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  k_cfg;
  logic [7:0]  m_cfg;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [15:0] stall_cnt;
  logic [1:0]  xr;
  bit          mode;
  int          n_vec;
  int          n_err;

  // Hand-computed word values (i*3+1) mod 4 for word i, repeating with period 4.
  logic [1:0]  exp_tbl [4] = '{2'd1, 2'd0, 2'd3, 2'd2};

  packet_xor_scheduler_if bus ();

  packet_xor_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .k_cfg_i     (k_cfg),
    .m_cfg_i     (m_cfg),
    .busy_o      (busy),
    .done_o      (done),
    .cfg_err_o   (cfg_err),
    .stall_cnt_o (stall_cnt),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mask RAM: row r is one-hot bit r (mode 0) or all ones (mode 1), one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mask_rd_en_o)
      bus.mask_rd_data_i <= mode ? {MASK_W{1'b1}} : (MASK_W'(1) << bus.mask_rd_addr_o);
  end

  // Datapath: XOR of every gated word, word i carrying (i*3+1) mod 4.
  always_comb begin
    xr = 2'd0;
    for (int i = 0; i < MASK_W; i++)
      if (bus.xor_mask_o[i]) xr = xr ^ 2'(i*3 + 1);
  end
  assign bus.xor_result_i = xr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_data(input int r);
    return mode ? 2'd0 : exp_tbl[r % 4];
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  512'(busy), 0);
    check({tag, "_done"},  512'(done), 0);
    check({tag, "_cfgerr"}, 512'(cfg_err), 0);
    check({tag, "_rden"},  512'(bus.mask_rd_en_o), 0);
    check({tag, "_addr"},  512'(bus.mask_rd_addr_o), 0);
    check({tag, "_mask"},  512'(bus.xor_mask_o), 0);
    check({tag, "_valid"}, 512'(bus.out_valid_o), 0);
    check({tag, "_data"},  512'(bus.out_data_o), 0);
    check({tag, "_row"},   512'(bus.out_row_o), 0);
    check({tag, "_stall"}, 512'(stall_cnt), 0);
  endtask

  task automatic cfg_reject(input logic [7:0] k, input logic [7:0] m);
    k_cfg = k; m_cfg = m; start = 1'b1;
    tick();
    start = 1'b0;
    check("cfgerr_pulse", 512'(cfg_err), 1);
    check("cfgerr_busy", 512'(busy), 0);
    check("cfgerr_rden", 512'(bus.mask_rd_en_o), 0);
    tick();
    check("cfgerr_clear", 512'(cfg_err), 0);
    check("cfgerr_idle", 512'(busy), 0);
    check("cfgerr_rden2", 512'(bus.mask_rd_en_o), 0);
  endtask

  // Starts a k=2 job and checks the FETCH/APPLY/CAPTURE pipeline up to first valid.
  task automatic start_job(input logic [7:0] k, input logic [7:0] m);
    bus.out_ready_i = 1'b1;
    k_cfg = k; m_cfg = m; start = 1'b1;
    tick();
    start = 1'b0;
    check("fetch_busy", 512'(busy), 1);
    check("fetch_rden", 512'(bus.mask_rd_en_o), 1);
    check("fetch_addr", 512'(bus.mask_rd_addr_o), 0);
    check("fetch_stall", 512'(stall_cnt), 0);
    tick();
    check("apply_valid", 512'(bus.out_valid_o), 0);
    check("apply_rden", 512'(bus.mask_rd_en_o), 0);
    tick();
    check("capture_mask", 512'(bus.xor_mask_o), mode ? 512'hFF : 512'h1);
    tick();
    check("latency_valid", 512'(bus.out_valid_o), 1);
  endtask

  task automatic collect(input int exp_rows, input int stall_row, input int poke_row, input int abort_row);
    int  got   = 0;
    int  stall = 0;
    int  cyc   = 0;
    bit  fin   = 1'b0;
    bit  acc;
    while (!fin) begin
      acc   = 1'b0;
      start = 1'b0;
      if (cyc >= 300) begin
        n_vec++;
        n_err++;
        $error("FAIL timeout rows_seen=%0d required=%0d", got, exp_rows);
        fin = 1'b1;
      end else if (bus.out_valid_o && got == abort_row) begin
        rst = 1'b1;
        #1;
        check_zero("abort");
        fin = 1'b1;
      end else if (bus.out_valid_o && got == stall_row && stall < 10) begin
        bus.out_ready_i = 1'b0;
        stall++;
        check("stall_row", 512'(bus.out_row_o), 512'(got));
        check("stall_data", 512'(bus.out_data_o), 512'(exp_data(got)));
      end else begin
        bus.out_ready_i = 1'b1;
        if (bus.out_valid_o) begin
          check("row", 512'(bus.out_row_o), 512'(got));
          check("data", 512'(bus.out_data_o), 512'(exp_data(got)));
          if (got == stall_row) begin
`ifdef PACKET_XOR_SCHED_STALL_CNT_EN
            check("stall_cnt", 512'(stall_cnt), 10);
`else
            check("stall_cnt", 512'(stall_cnt), 0);
`endif
          end
          if (got == poke_row) begin
            start = 1'b1; k_cfg = 8'd2; m_cfg = 8'd4;
          end
          $display("row %0d data %0d", bus.out_row_o, bus.out_data_o);
          got++;
          acc = 1'b1;
        end
      end
      if (!fin) begin
        tick();
        cyc++;
        if (acc) begin
          check("done_timing", 512'(done), 512'(got == exp_rows));
          check("valid_drop", 512'(bus.out_valid_o), 0);
        end
        if (done) begin
          check("done_busy", 512'(busy), 1);
          fin = 1'b1;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic job_end();
    tick();
    check("end_busy", 512'(busy), 0);
    check("end_done", 512'(done), 0);
    check("end_mask", 512'(bus.xor_mask_o), 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; k_cfg = '0; m_cfg = '0; mode = 1'b0;
    bus.out_ready_i = 1'b1;
    tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("idle");

    cfg_reject(8'd1, 8'd2);
    cfg_reject(8'd2, 8'd129);

    // One-hot masks, ready always high.
    mode = 1'b0;
    start_job(8'd2, 8'd2);
    collect(8, -1, -1, -1);
    job_end();

    // All-ones masks trimmed to k=2, with row 3 held off for 10 cycles.
    mode = 1'b1;
    start_job(8'd2, 8'd2);
    collect(8, 3, -1, -1);
    job_end();

    // start_i while busy must not disturb the job.
    mode = 1'b0;
    start_job(8'd2, 8'd2);
    collect(8, -1, 3, -1);
    job_end();

    // Reset in the OUT state of row 5, then a fresh job from row 0.
    start_job(8'd2, 8'd2);
    collect(8, -1, -1, 5);
    tick();
    check_zero("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_done", 512'(done), 0);
      check("post_reset_busy", 512'(busy), 0);
    end
    start_job(8'd2, 8'd2);
    collect(8, -1, -1, -1);
    job_end();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/packet_xor_scheduler.md
Name: packet_xor_scheduler

Overview:
- Sequences the shared packet-XOR datapath (gated per-word XOR tree over K_MAX packets × W words) to produce all parity rows of one encode job.
- For each parity row, fetches that row's bitmatrix mask from coding-matrix RAM, trims it to the configured K, drives it to the datapath and captures the XOR result.
- Delivers each result on a valid/ready output stream, in row order.

Parameters:
- K_MAX, 128, maximum data packets.
- K_MIN, 2, minimum legal k.
- M_MAX, 128, maximum parity packets.
- M_MIN, 2, minimum legal m.
- W, 4, words per packet (Galois field width).
- PACKET_LENGTH, 2, bits per word / result width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  job start pulse; sampled in IDLE only.
- k_cfg_i  in  $clog2(K_MAX+1)  number of data packets; sampled with start_i.
- m_cfg_i  in  $clog2(M_MAX+1)  number of parity packets; sampled with start_i.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse after the last row is accepted.
- cfg_err_o  out  1  one-cycle pulse when start_i carries illegal k/m.
- mask_rd_en_o  out  1  mask RAM read strobe.
- mask_rd_addr_o  out  $clog2(M_MAX*W)  parity row index.
- mask_rd_data_i  in  K_MAX*W  mask RAM data, valid 1 cycle after read.
- xor_mask_o  out  K_MAX*W  gating mask to datapath; bit index = pkt*W+word.
- xor_result_i  in  PACKET_LENGTH  combinational datapath result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accept.
- out_data_o  out  PACKET_LENGTH  captured XOR result.
- out_row_o  out  $clog2(M_MAX*W)  row index of out_data_o.
- stall_cnt_o  out  16  backpressure counter (optional feature).

Behaviour:
- Clock/reset: one clock `clk`; `rst` is asynchronous and active-high. Asserting rst at any time, including mid-job, forces all outputs to 0 and state to IDLE immediately; the job is abandoned with no done_o.
- Legality check: start_i in IDLE with K_MIN≤k≤K_MAX and M_MIN≤m≤M_MAX latches k, m, sets row=0 and goes to FETCH. Otherwise cfg_err_o pulses for 1 cycle and the block stays IDLE. start_i outside IDLE is ignored.
- Total rows: R = m*W; rows run 0..R-1.
- FETCH: mask_rd_en_o=1, mask_rd_addr_o=row; next state APPLY.
- APPLY: register mask_rd_data_i with bits pkt≥k forced to 0, and drive xor_mask_o from that register. Next state CAPTURE.
- CAPTURE: sample xor_result_i into out_data_o and row into out_row_o. out_valid_o=1 from the next cycle; next state OUT.
- OUT: hold out_valid_o, out_data_o and out_row_o stable until out_valid_o && out_ready_i.
  - On accept with row<R-1: row++ and go to FETCH, with out_valid_o low next cycle.
  - On accept with row=R-1: go to DONE.
- DONE: done_o=1 for 1 cycle, busy_o=0 next cycle, return to IDLE.
- busy_o=1 in FETCH, APPLY, CAPTURE, OUT and DONE.
- xor_mask_o holds its value between rows and is cleared to 0 on entering IDLE.
- Throughput: 4 cycles/row minimum (FETCH, APPLY, CAPTURE, OUT with ready=1).
- Counters: row counter never exceeds R-1; there is no wrap.
- Latency: start_i to first out_valid_o is 4 cycles.
- Reset values: all outputs 0; state IDLE.

Optional Feature:
- Macro: PACKET_XOR_SCHED_STALL_CNT_EN.
- Defined: stall_cnt_o increments on every cycle with out_valid_o=1 and out_ready_i=0. It saturates at 16'hFFFF and clears on each accepted start_i and on rst.
- Undefined: stall_cnt_o is tied to 0 and no counter logic is synthesized.

Test Plan:
- k=2, m=2, W=4, ready=1, mask row r = 1<<r, datapath model XOR → exactly 8 results, rows 0..7 in order. First out_valid_o 4 cycles after start_i; done_o 1 cycle after the row-7 accept.
- k=2 with mask_rd_data_i all-ones → xor_mask_o has only bits 0..7 set; all bits ≥8 are zero.
- start_i with k=1 and m=2, then with k=2 and m=129 → cfg_err_o pulses each time; busy_o stays 0; no mask reads issued.
- ready held low 10 cycles on row 3 → out_data_o and out_row_o=3 stable; stall_cnt_o=10 with macro defined, 0 without.
- rst asserted during OUT of row 5 → all outputs 0 asynchronously; no done_o. A new start_i afterwards restarts from row 0.
- start_i pulsed while busy → ignored; row sequence and total count unchanged.
